// File: rtl/lag_measure_ctrl.sv
// Lag measurement sequencer: arms on the video trigger edge, times in BCD 10 us ticks
// until the photodiode responds, and keeps last/min/max/count statistics for on-screen display.
module lag_measure_ctrl #(
    parameter int          TICK_DIV    = 742,
    parameter logic [19:0] TIMEOUT_BCD = 20'h10000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear_stats,
    input  logic        starttrigger,
    input  logic        sensor,
    output logic [79:0] bcdcount,
    output logic        busy,
    output logic        sample_valid,
    output logic        timeout
);

    localparam int          PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [19:0] MIN_INIT = 20'h99999;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t        state, state_next;
    logic          sens_meta, sens_sync, sens_prev, trig_d;
    logic          sensor_rise, trig_rise;
    logic          commit, abort_timeout, start_measure;
    logic          seen_low;
    logic [PW-1:0] prescaler;
    logic [19:0]   lag_acc;
    logic [19:0]   last_r, min_r, max_r, count_r;

    // Five-digit packed BCD increment with per-digit 9->0 carry; 99999 wraps to 00000.
    function automatic logic [19:0] bcd_inc(input logic [19:0] v);
        logic [19:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sens_meta <= 1'b0;
            sens_sync <= 1'b0;
            sens_prev <= 1'b0;
            trig_d    <= 1'b0;
        end else begin
            sens_meta <= sensor;
            sens_sync <= sens_meta;
            sens_prev <= sens_sync;
            trig_d    <= starttrigger;
        end
    end

    assign sensor_rise = sens_sync & ~sens_prev;
    assign trig_rise   = starttrigger & ~trig_d;
    assign busy        = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // A sensor edge in the same cycle as the timeout value takes priority over the abort.
    always_comb begin
        state_next    = state;
        commit        = 1'b0;
        abort_timeout = 1'b0;
        start_measure = 1'b0;
        case (state)
            IDLE: begin
                state_next = ARM;
            end
            ARM: begin
                if (trig_rise) begin
                    state_next    = MEASURE;
                    start_measure = 1'b1;
                end
            end
            MEASURE: begin
                if (sensor_rise) begin
                    commit     = 1'b1;
                    state_next = HOLDOFF;
                end else if (lag_acc == TIMEOUT_BCD) begin
                    abort_timeout = 1'b1;
                    state_next    = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (seen_low && trig_rise) begin
                    state_next    = MEASURE;
                    start_measure = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next    = IDLE;
            commit        = 1'b0;
            abort_timeout = 1'b0;
            start_measure = 1'b0;
        end
    end

    // seen_low only becomes set once the light has gone dark after entering HOLDOFF.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prescaler <= '0;
            lag_acc   <= '0;
            seen_low  <= 1'b0;
        end else begin
            if (start_measure) begin
                prescaler <= '0;
                lag_acc   <= '0;
            end else if (state == MEASURE) begin
                if (prescaler == PS_LAST) begin
                    prescaler <= '0;
                    lag_acc   <= bcd_inc(lag_acc);
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
            if (state != HOLDOFF)  seen_low <= 1'b0;
            else if (!sens_sync)   seen_low <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear_stats) begin
            last_r  <= '0;
            min_r   <= MIN_INIT;
            max_r   <= '0;
            count_r <= '0;
        end else if (commit) begin
            last_r <= lag_acc;
            if (lag_acc < min_r)        min_r   <= lag_acc;
            if (lag_acc > max_r)        max_r   <= lag_acc;
            if (count_r != MIN_INIT)    count_r <= bcd_inc(count_r);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sample_valid <= 1'b0;
            timeout      <= 1'b0;
            bcdcount     <= {20'h0, MIN_INIT, 20'h0, 20'h0};
        end else begin
            sample_valid <= commit & ~clear_stats;
            timeout      <= abort_timeout;
            bcdcount     <= {last_r, min_r, max_r, count_r};
        end
    end

endmodule
